// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the controller state encoding, the master-id type and the
// byte-strobe merge used by the read-modify-write path (DMEM_RMW_EN).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RMW_WR = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    // Per-byte merge: bytes with a set strobe come from new_data, the rest from old_data.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_data,
                                               input logic [31:0] new_data,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_data;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one master of the data-memory arbiter.
// The master modport is the requester's view; the slave modport is the
// arbiter's view.
interface dmem_arbiter_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb.sv
// Two-way round-robin picker. A lone request wins outright; on a conflict
// the master that did not win last time is chosen.
module dmem_rr_arb
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_gnt,
    output logic [1:0] gnt
);

    // Pick a winner from the current requests, alternating on conflicts.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == M0) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data_mem between the core
// load/store unit (m0) and the loader/debug port (m1). One access is issued
// per cycle with round-robin arbitration, read data is steered back to the
// master that issued the read, and a whole-memory clear sweep is sequenced
// on request.
// Optional feature macro: DMEM_RMW_EN adds byte-strobe writes done as a
// read-modify-write; without it every write is a full-word write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRW = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_arbiter_if.slave      m0,
    dmem_arbiter_if.slave      m1,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_din,
    input  logic [31:0]        mem_dout
);

    localparam int             WORDS    = 1 << ADDRW;
    localparam logic [ADDRW:0] LAST_IDX = (ADDRW + 1)'(WORDS - 1);

    arb_state_t        state_q, state_d;
    master_id_t        last_gnt_q;
    logic [ADDRW:0]    cnt_q;
    logic              rd_valid_q;
    master_id_t        rd_owner_q;
    logic [31:0]       rdata0_q, rdata1_q;

    logic [1:0]        arb_req;
    logic [1:0]        rr_gnt;
    logic              gnt_en;
    logic              issue_rd;
    logic              clear_go;
    master_id_t        win_id;
    logic              win_we;
    logic [31:0]       win_addr;
    logic [31:0]       win_wdata;
    logic [ADDRW-1:0]  win_idx;
    logic              rvalid0, rvalid1;

`ifdef DMEM_RMW_EN
    logic [3:0]        win_wstrb;
    logic              rmw_start;
    logic [ADDRW-1:0]  rmw_idx_q;
    logic [31:0]       rmw_wdata_q;
    logic [3:0]        rmw_wstrb_q;
    logic              clear_pend_q;
`endif

    logic              unused_bits;

    // Word index placed on the memory bus with the byte offset zeroed.
    function automatic logic [31:0] word_addr(input logic [ADDRW-1:0] idx);
        return {{(30 - ADDRW){1'b0}}, idx, 2'b00};
    endfunction

    assign arb_req = {m1.req, m0.req};

    dmem_rr_arb u_rr (
        .req      (arb_req),
        .last_gnt (last_gnt_q),
        .gnt      (rr_gnt)
    );

    assign win_id    = rr_gnt[1] ? M1 : M0;
    assign win_we    = (win_id == M1) ? m1.we    : m0.we;
    assign win_addr  = (win_id == M1) ? m1.addr  : m0.addr;
    assign win_wdata = (win_id == M1) ? m1.wdata : m0.wdata;
    assign win_idx   = win_addr[ADDRW+1:2];

`ifdef DMEM_RMW_EN
    assign win_wstrb = (win_id == M1) ? m1.wstrb : m0.wstrb;
    assign clear_go  = clear_req | clear_pend_q;
    assign unused_bits = ^{m0.addr[31:ADDRW+2], m0.addr[1:0],
                           m1.addr[31:ADDRW+2], m1.addr[1:0]};
`else
    assign clear_go  = clear_req;
    assign unused_bits = ^{m0.addr[31:ADDRW+2], m0.addr[1:0],
                           m1.addr[31:ADDRW+2], m1.addr[1:0],
                           m0.wstrb, m1.wstrb};
`endif

    // Next-state and memory-bus decode: arbitrate in IDLE, sweep in CLEAR,
    // write back the merged word in RMW_WR.
    always_comb begin
        state_d  = state_q;
        gnt_en   = 1'b0;
        issue_rd = 1'b0;
        mem_we   = 1'b0;
        mem_addr = 32'h0;
        mem_din  = 32'h0;
`ifdef DMEM_RMW_EN
        rmw_start = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (clear_go) begin
                    state_d = CLEAR;
                end else if (|arb_req) begin
                    gnt_en   = 1'b1;
                    mem_addr = word_addr(win_idx);
                    if (win_we) begin
`ifdef DMEM_RMW_EN
                        if (win_wstrb == 4'hF) begin
                            mem_we  = 1'b1;
                            mem_din = win_wdata;
                        end else if (win_wstrb != 4'h0) begin
                            rmw_start = 1'b1;
                            state_d   = RMW_WR;
                        end
`else
                        mem_we  = 1'b1;
                        mem_din = win_wdata;
`endif
                    end else begin
                        issue_rd = 1'b1;
                    end
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = word_addr(cnt_q[ADDRW-1:0]);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
`ifdef DMEM_RMW_EN
            RMW_WR: begin
                mem_we   = 1'b1;
                mem_addr = word_addr(rmw_idx_q);
                mem_din  = strb_merge(mem_dout, rmw_wdata_q, rmw_wstrb_q);
                state_d  = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m0.gnt     = gnt_en & rr_gnt[0];
    assign m1.gnt     = gnt_en & rr_gnt[1];
    assign clear_busy = (state_q == CLEAR);

    // State register and round-robin history; m0 wins the first conflict after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= M1;
        end else begin
            state_q <= state_d;
            if (gnt_en) begin
                last_gnt_q <= win_id;
            end
        end
    end

    // Sweep index: restarts at zero from IDLE and parks at the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            if (cnt_q != LAST_IDX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // Remember who issued a read so the returning data goes to that master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= M0;
        end else begin
            rd_valid_q <= issue_rd;
            if (issue_rd) begin
                rd_owner_q <= win_id;
            end
        end
    end

    assign rvalid0 = rd_valid_q & (rd_owner_q == M0);
    assign rvalid1 = rd_valid_q & (rd_owner_q == M1);

    // Keep the last returned word per master so rdata is stable between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            if (rvalid0) begin
                rdata0_q <= mem_dout;
            end
            if (rvalid1) begin
                rdata1_q <= mem_dout;
            end
        end
    end

    assign m0.rvalid = rvalid0;
    assign m1.rvalid = rvalid1;
    assign m0.rdata  = rvalid0 ? mem_dout : rdata0_q;
    assign m1.rdata  = rvalid1 ? mem_dout : rdata1_q;

`ifdef DMEM_RMW_EN
    // Capture the partial write so the merge can complete while the old word returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmw_idx_q   <= '0;
            rmw_wdata_q <= 32'h0;
            rmw_wstrb_q <= 4'h0;
        end else if (rmw_start) begin
            rmw_idx_q   <= win_idx;
            rmw_wdata_q <= win_wdata;
            rmw_wstrb_q <= win_wstrb;
        end
    end

    // A clear pulse arriving during the merge write is held until IDLE can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_pend_q <= 1'b0;
        end else if (state_q == RMW_WR && clear_req) begin
            clear_pend_q <= 1'b1;
        end else if (state_q == IDLE) begin
            clear_pend_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural data_mem plus a reference model
// of the arbiter kept as a word array, a round-robin history and per-master
// expected read returns. Honours DMEM_RMW_EN when it is defined.
module tb_dmem_arbiter;

    localparam int ADDRW = 6;
    localparam int WORDS = 1 << ADDRW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        seed_mem = 1'b1;

    dmem_arbiter_if if0 ();
    dmem_arbiter_if if1 ();

    dmem_arbiter #(.ADDRW(ADDRW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (if0),
        .m1         (if1),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seedPat(input int i);
        return 32'hA5000000 | (32'(i) * 32'h00010101);
    endfunction

    // Behavioural single-port data_mem: registered read, write commits at the edge.
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= seedPat(i);
        end else begin
            if (mem_we) ram[mem_addr[ADDRW+1:2]] <= mem_din;
            mem_dout <= ram[mem_addr[ADDRW+1:2]];
        end
    end

    logic [31:0] model_mem [WORDS];
    int          last_m = 1;
    bit          pend [2];
    bit          t_we [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wd [2];
    logic [3:0]  t_st [2];
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          stall = 1'b0;
    logic [31:0] stall_data = 32'h0;
    logic [1:0]  obs_gnt;
    int          compared = 0;
    int          mismatched = 0;

    function automatic logic [31:0] refMerge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        if0.req = pend[0]; if0.we = t_we[0]; if0.addr = t_addr[0];
        if0.wdata = t_wd[0]; if0.wstrb = t_st[0];
        if1.req = pend[1]; if1.we = t_we[1]; if1.addr = t_addr[1];
        if1.wdata = t_wd[1]; if1.wstrb = t_st[1];
    endtask

    task automatic setTxn(input int m, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st);
        pend[m] = 1'b1; t_we[m] = we; t_addr[m] = addr; t_wd[m] = wd; t_st[m] = st;
    endtask

    task automatic newRandomTxn(input int m);
        logic [3:0] st;
        int sel;
        sel = int'($urandom_range(0, 3));
        st = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
        setTxn(m, bit'($urandom_range(0, 1)), $urandom, $urandom, st);
    endtask

    // One arbiter cycle: entered just after a rising edge, compares at the falling edge.
    task automatic runCycle();
        int          w;
        int          idx;
        bit          nrv [2];
        logic [31:0] nrd [2];
        bit          nstall;
        applyStimulus();
        @(negedge clk);
        w = -1; nrv = '{1'b0, 1'b0}; nrd = '{32'h0, 32'h0}; nstall = 1'b0;
        if (!stall) begin
            if (pend[0] && pend[1]) w = (last_m == 0) ? 1 : 0;
            else if (pend[0]) w = 0;
            else if (pend[1]) w = 1;
        end
        obs_gnt = {if1.gnt, if0.gnt};
        checkOutput("m0_gnt", 64'(if0.gnt), 64'(w == 0));
        checkOutput("m1_gnt", 64'(if1.gnt), 64'(w == 1));
        checkOutput("m0_rvalid", 64'(if0.rvalid), 64'(exp_rv[0]));
        checkOutput("m1_rvalid", 64'(if1.rvalid), 64'(exp_rv[1]));
        if (exp_rv[0]) checkOutput("m0_rdata", 64'(if0.rdata), 64'(exp_rd[0]));
        if (exp_rv[1]) checkOutput("m1_rdata", 64'(if1.rdata), 64'(exp_rd[1]));
        if (stall) checkOutput("rmw_write", {31'h0, mem_we, mem_din}, {31'h0, 1'b1, stall_data});
        if (w >= 0) begin
            idx = int'((t_addr[w] >> 2) % WORDS);
            checkOutput("mem_addr", 64'(mem_addr), 64'(idx * 4));
            last_m = w;
            if (!t_we[w]) begin
                checkOutput("rd_mem_we", 64'(mem_we), 64'(0));
                nrv[w] = 1'b1;
                nrd[w] = model_mem[idx];
            end else begin
`ifdef DMEM_RMW_EN
                if (t_st[w] == 4'hF) begin
                    checkOutput("wr_bus", {31'h0, mem_we, mem_din}, {31'h0, 1'b1, t_wd[w]});
                    model_mem[idx] = t_wd[w];
                end else begin
                    checkOutput("wr_mem_we", 64'(mem_we), 64'(0));
                    if (t_st[w] != 4'h0) begin
                        model_mem[idx] = refMerge(model_mem[idx], t_wd[w], t_st[w]);
                        nstall = 1'b1;
                        stall_data = model_mem[idx];
                    end
                end
`else
                checkOutput("wr_bus", {31'h0, mem_we, mem_din}, {31'h0, 1'b1, t_wd[w]});
                model_mem[idx] = t_wd[w];
`endif
            end
            pend[w] = 1'b0;
        end
        @(posedge clk); #1;
        exp_rv = nrv; exp_rd = nrd; stall = nstall;
    endtask

    // Clear sweep with m0 requesting alongside; abort_after>0 resets mid-sweep.
    task automatic doClear(input int abort_after);
        int busy;
        bit done;
        busy = 0; done = 1'b0;
        clear_req = 1'b1;
        setTxn(0, 1'b0, 32'h4, 32'h0, 4'hF);
        applyStimulus();
        @(negedge clk);
        checkOutput("clr_req_m0_gnt", 64'(if0.gnt), 64'(0));
        @(posedge clk); #1;
        clear_req = 1'b0;
        for (int c = 0; c < WORDS + 8 && !done; c++) begin
            @(negedge clk);
            if (!clear_busy) begin
                done = 1'b1;
            end else begin
                checkOutput("clr_m0_gnt", 64'(if0.gnt), 64'(0));
                checkOutput("clr_addr", 64'(mem_addr), 64'(busy * 4));
                checkOutput("clr_we_din", {31'h0, mem_we, mem_din}, {31'h0, 1'b1, 32'h0});
                busy++;
                if (abort_after != 0 && busy == abort_after) done = 1'b1;
                else begin @(posedge clk); #1; end
            end
        end
        if (abort_after != 0) begin
            checkOutput("abort_busy_count", 64'(busy), 64'(abort_after));
            @(posedge clk); #1;
            rst_n = 1'b0;
            pend[0] = 1'b0;
            applyStimulus();
            @(negedge clk);
            checkOutput("rst_clear_busy", 64'(clear_busy), 64'(0));
            checkOutput("rst_mem_we", 64'(mem_we), 64'(0));
            checkOutput("rst_m0_gnt", 64'(if0.gnt), 64'(0));
            @(posedge clk); #1;
            rst_n = 1'b1;
            last_m = 1; exp_rv = '{1'b0, 1'b0}; stall = 1'b0;
            for (int i = 0; i < abort_after; i++) model_mem[i] = 32'h0;
        end else begin
            checkOutput("clear_busy_cycles", 64'(busy), 64'(WORDS));
            checkOutput("post_clr_m0_gnt", 64'(if0.gnt), 64'(1));
            for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
            last_m = 0; pend[0] = 1'b0;
            @(posedge clk); #1;
            exp_rv = '{1'b1, 1'b0}; exp_rd = '{32'h0, 32'h0}; stall = 1'b0;
        end
    endtask

    initial begin
        pend = '{1'b0, 1'b0}; t_we = '{1'b0, 1'b0};
        t_addr = '{32'h0, 32'h0}; t_wd = '{32'h0, 32'h0}; t_st = '{4'h0, 4'h0};
        exp_rv = '{1'b0, 1'b0}; exp_rd = '{32'h0, 32'h0};
        applyStimulus();
        for (int i = 0; i < WORDS; i++) model_mem[i] = seedPat(i);

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1 seed_mem = 1'b0;
        @(negedge clk);
        checkOutput("rst_m0_gnt", 64'(if0.gnt), 64'(0));
        checkOutput("rst_m1_gnt", 64'(if1.gnt), 64'(0));
        checkOutput("rst_rvalid", {62'h0, if1.rvalid, if0.rvalid}, 64'(0));
        checkOutput("rst_busy_we", {62'h0, clear_busy, mem_we}, 64'(0));
        checkOutput("rst_rdata", {if1.rdata, if0.rdata}, 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] conflicting reads");
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) setTxn(0, 1'b0, 32'h4, 32'h0, 4'hF);
            if (!pend[1]) setTxn(1, 1'b0, 32'h8, 32'h0, 4'hF);
            runCycle();
            checkOutput("conflict_seq", 64'(obs_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        pend = '{1'b0, 1'b0};
        runCycle();

        $display("[TB] write then read");
        setTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        runCycle();
        setTxn(1, 1'b0, 32'h10, 32'h0, 4'hF);
        runCycle();
        runCycle();
        checkOutput("wr_rd_m1_rdata", 64'(if1.rdata), 64'hDEADBEEF);

        $display("[TB] clear with reset mid-sweep, then full clear");
        doClear(10);
        setTxn(1, 1'b0, 32'h0, 32'h0, 4'hF);
        runCycle();
        doClear(0);
        for (int i = 0; i < 6; i++) begin
            setTxn(i % 2, 1'b0, 32'(i * 44), 32'h0, 4'hF);
            runCycle();
        end
        runCycle();
        checkOutput("post_clr_rdata", {if1.rdata, if0.rdata}, 64'(0));

        $display("[TB] byte-strobe writes");
        setTxn(0, 1'b1, 32'h8, 32'h11223344, 4'hF);
        runCycle();
        setTxn(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101);
        runCycle();
        setTxn(1, 1'b0, 32'h8, 32'h0, 4'hF);
        runCycle();
`ifdef DMEM_RMW_EN
        checkOutput("rmw_stall_gnt", 64'(obs_gnt), 64'h0);
`else
        checkOutput("rmw_stall_gnt", 64'(obs_gnt), 64'h2);
`endif
        runCycle();
        runCycle();
`ifdef DMEM_RMW_EN
        checkOutput("rmw_rdata", 64'(if1.rdata), 64'h11BB33DD);
`else
        checkOutput("rmw_rdata", 64'(if1.rdata), 64'hAABBCCDD);
`endif
        setTxn(0, 1'b1, 32'h8, 32'h12345678, 4'h0);
        runCycle();
        setTxn(1, 1'b0, 32'h8, 32'h0, 4'hF);
        runCycle();
        runCycle();
`ifdef DMEM_RMW_EN
        checkOutput("strb0_rdata", 64'(if1.rdata), 64'h11BB33DD);
`else
        checkOutput("strb0_rdata", 64'(if1.rdata), 64'h12345678);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 9) < 7) newRandomTxn(m);
            end
            runCycle();
        end
        pend = '{1'b0, 1'b0};
        repeat (3) runCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
